// File: rtl/aes_core_arbiter.sv
// ============================================================================
// Module   : aes_core_arbiter
// Purpose  : Round-robin arbiter sharing one AES core among NUM_REQ requesters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_core_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_enc_dec,
   input  logic [2*NUM_REQ-1:0]   req_mode,
   input  logic [256*NUM_REQ-1:0] req_key,
   input  logic [128*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [127:0]           resp_data,
   output logic                   resp_error,
   output logic                   core_start,
   output logic                   core_enc_dec,
   output logic [1:0]             core_mode,
   output logic [255:0]           core_key,
   output logic [127:0]           core_data_in,
   input  logic [127:0]           core_data_out,
   input  logic                   core_done
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            op_enc_dec_q, op_enc_dec_d;
   logic [1:0]      op_mode_q, op_mode_d;
   logic [255:0]    op_key_q, op_key_d;
   logic [127:0]    op_data_q, op_data_d;
   logic [127:0]    resp_data_q, resp_data_d;
   logic            resp_error_q, resp_error_d;

   logic [IW-1:0]   sel_idx;
   logic            sel_found;
   logic [IW:0]     sum;
   logic [IW:0]     nxt;

   // Search upward from rr_ptr, wrapping at NUM_REQ, for the first valid request.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      sum       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
         if (!sel_found && req_valid[sum[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = sum[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      op_enc_dec_d = op_enc_dec_q;
      op_mode_d    = op_mode_q;
      op_key_d     = op_key_q;
      op_data_d    = op_data_q;
      resp_data_d  = resp_data_q;
      resp_error_d = resp_error_q;
      req_ready    = '0;
      nxt          = {1'b0, grant_q} + (IW+1)'(1);
      if (nxt == (IW+1)'(NUM_REQ)) nxt = '0;

      case (state_q)
         IDLE: begin
            if (sel_found) begin
               req_ready[sel_idx] = !reset;
               grant_d      = sel_idx;
               op_enc_dec_d = req_enc_dec[sel_idx];
               op_mode_d    = req_mode[2*sel_idx +: 2];
               op_key_d     = req_key[256*sel_idx +: 256];
               op_data_d    = req_data[128*sel_idx +: 128];
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            // core_done is tested first so it wins over a simultaneous timeout.
            if (core_done) begin
               resp_data_d  = core_data_out;
               resp_error_d = 1'b0;
               state_d      = RESP;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               resp_data_d  = '0;
               resp_error_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            if (resp_ready[grant_q]) begin
               rr_ptr_d = nxt[IW-1:0];
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         cnt_q        <= '0;
         op_enc_dec_q <= 1'b0;
         op_mode_q    <= '0;
         op_key_q     <= '0;
         op_data_q    <= '0;
         resp_data_q  <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         op_enc_dec_q <= op_enc_dec_d;
         op_mode_q    <= op_mode_d;
         op_key_q     <= op_key_d;
         op_data_q    <= op_data_d;
         resp_data_q  <= resp_data_d;
         resp_error_q <= resp_error_d;
      end
   end

   always_comb begin
      resp_valid = '0;
      if (state_q == RESP) resp_valid[grant_q] = 1'b1;
   end

   assign core_start   = (state_q == ISSUE);
   assign core_enc_dec = op_enc_dec_q;
   assign core_mode    = op_mode_q;
   assign core_key     = op_key_q;
   assign core_data_in = op_data_q;
   assign resp_data    = resp_data_q;
   assign resp_error   = resp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
// ============================================================================
// Module   : tb_aes_core_arbiter
// Purpose  : Directed self-checking bench for aes_core_arbiter (2 requesters)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_core_arbiter;

   localparam int NUM_REQ = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     req_enc_dec;
   logic [2*NUM_REQ-1:0]   req_mode;
   logic [256*NUM_REQ-1:0] req_key;
   logic [128*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]     resp_valid;
   logic [NUM_REQ-1:0]     resp_ready;
   logic [127:0]           resp_data;
   logic                   resp_error;
   logic                   core_start;
   logic                   core_enc_dec;
   logic [1:0]             core_mode;
   logic [255:0]           core_key;
   logic [127:0]           core_data_in;
   logic [127:0]           core_data_out;
   logic                   core_done;

   int n_cmp = 0;
   int n_err = 0;
   int g;
   logic [1:0]   oh;
   logic [255:0] key0;
   logic [127:0] pt0, ct0, d0, d1, x1, y1;

   aes_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
      .req_mode(req_mode), .req_key(req_key), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_error(resp_error), .core_start(core_start), .core_enc_dec(core_enc_dec),
      .core_mode(core_mode), .core_key(core_key), .core_data_in(core_data_in),
      .core_data_out(core_data_out), .core_done(core_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"},  req_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_data"},  resp_data, 0);
      chk({tag, "_resp_error"}, resp_error, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_core_encdec"}, core_enc_dec, 0);
      chk({tag, "_core_mode"},  core_mode, 0);
      chk({tag, "_core_key"},   core_key, 0);
      chk({tag, "_core_din"},   core_data_in, 0);
   endtask

   initial begin
      key0 = 256'h000102030405060708090a0b0c0d0e0f;
      pt0  = 128'h00112233445566778899aabbccddeeff;
      ct0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      d0   = 128'hd0d0d0d0_00000000_11111111_d0d0d0d0;
      d1   = 128'hd1d1d1d1_22222222_33333333_d1d1d1d1;
      x1   = 128'hcafebabe_0badf00d_12345678_9abcdef0;
      y1   = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

      reset = 1'b1; req_valid = '0; req_enc_dec = '0; req_mode = '0;
      req_key = '0; req_data = '0; resp_ready = '0;
      core_data_out = '0; core_done = 1'b0;
      step(); step();
      chk_all_zero("reset");
      reset = 1'b0;

      // Single encipher on requester 0
      req_valid = 2'b01; req_key[255:0] = key0; req_data[127:0] = pt0;
      #1 chk("enc_accept", req_ready, 2'b01);
      step(); req_valid = '0;
      chk("enc_start", core_start, 1);
      chk("enc_key", core_key, key0);
      chk("enc_din", core_data_in, pt0);
      chk("enc_mode", core_mode, 0);
      chk("enc_encdec", core_enc_dec, 0);
      chk("enc_issue_rdy", req_ready, 0);
      step();
      chk("enc_start_once", core_start, 0);
      core_done = 1'b1; core_data_out = ct0;
      step(); core_done = 1'b0; core_data_out = 128'hdead;
      chk("enc_resp_valid", resp_valid, 2'b01);
      chk("enc_resp_data", resp_data, ct0);
      chk("enc_resp_err", resp_error, 0);
      resp_ready = 2'b01;
      step(); resp_ready = '0;
      chk("enc_idle_valid", resp_valid, 0);

      // Contention after reset: grants alternate 0,1,0,1
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 2'b11; req_enc_dec = 2'b10; req_mode = 4'b1101;
      req_data = {d1, d0};
      for (int i = 0; i < 4; i++) begin
         g  = i % 2;
         oh = 2'b01 << g;
         #1 chk("cont_grant", req_ready, oh);
         step();
         chk("cont_issue_rdy", req_ready, 0);
         chk("cont_mode", core_mode, (g == 1) ? 2'b11 : 2'b01);
         chk("cont_encdec", core_enc_dec, (g == 1) ? 1'b1 : 1'b0);
         chk("cont_din", core_data_in, (g == 1) ? d1 : d0);
         step();
         chk("cont_busy_rdy", req_ready, 0);
         core_done = 1'b1; core_data_out = (g == 1) ? d0 : d1;
         step(); core_done = 1'b0;
         chk("cont_resp", resp_valid, oh);
         chk("cont_resp_rdy", req_ready, 0);
         resp_ready = 2'b11;
         step(); resp_ready = '0;
      end

      // Backpressure on requester 1; resp_ready[0] must be ignored
      req_valid = 2'b10;
      #1 chk("bp_grant", req_ready, 2'b10);
      step(); req_valid = 2'b11;
      step(); core_done = 1'b1; core_data_out = x1;
      step(); core_done = 1'b0; core_data_out = '0;
      resp_ready = 2'b01;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("bp_valid", resp_valid, 2'b10);
         chk("bp_data", resp_data, x1);
         chk("bp_rdy", req_ready, 0);
         step();
      end
      resp_ready = 2'b10;
      step(); resp_ready = '0;
      chk("bp_release", resp_valid, 0);

      // Timeout with TIMEOUT = 16: 16 BUSY cycles, then error response
      req_valid = 2'b01;
      #1 chk("to_grant", req_ready, 2'b01);
      step(); req_valid = '0; core_data_out = y1;
      step();
      for (int i = 0; i < 15; i++) step();
      chk("to_not_yet", resp_valid, 0);
      step();
      chk("to_valid", resp_valid, 2'b01);
      chk("to_err", resp_error, 1);
      chk("to_data", resp_data, 0);
      resp_ready = 2'b01;
      step(); resp_ready = '0;

      // Next request accepted normally; done collides with timeout cycle
      req_valid = 2'b01;
      #1 chk("after_to_grant", req_ready, 2'b01);
      step(); req_valid = '0;
      step();
      for (int i = 0; i < 15; i++) step();
      chk("coll_not_yet", resp_valid, 0);
      core_done = 1'b1; core_data_out = y1;
      step(); core_done = 1'b0; core_data_out = '0;
      chk("coll_valid", resp_valid, 2'b01);
      chk("coll_err", resp_error, 0);
      chk("coll_data", resp_data, y1);
      resp_ready = 2'b01;
      step(); resp_ready = '0;

      // Reset mid-BUSY, five cycles after core_start (rr_ptr was 1)
      req_valid = 2'b10;
      #1 chk("rst_grant", req_ready, 2'b10);
      step(); req_valid = '0;
      chk("rst_start", core_start, 1);
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1; core_done = 1'b1; core_data_out = x1;
      step(); reset = 1'b0; core_done = 1'b0;
      chk_all_zero("rst_mid");
      step(); step();
      chk("rst_no_resp", resp_valid, 0);
      req_valid = 2'b11;
      #1 chk("rst_ptr0", req_ready, 2'b01);
      step(); req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
